// File: rtl/btn_conditioner_pkg.sv
// Shared constants and types for the push-button front end: button indices,
// default 100 MHz timing and the hold/repeat phase encoding.
package btn_conditioner_pkg;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_D = 4;

  localparam int unsigned DEF_NUM_BTN         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;  // 0.1 s

  // Per-channel long-press phase: waiting for the first hold strobe, or repeating.
  typedef enum logic {
    HOLD_WAIT   = 1'b0,
    HOLD_REPEAT = 1'b1
  } hold_phase_t;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: 2-FF synchroniser, restart-on-glitch debouncer,
// registered press/release strobes and long-press auto-repeat strobe.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease,
  output logic btnHold
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(maxU(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [1:0]        syncQ;
  logic              stableQ, stableD;
  logic [DB_W-1:0]   dbCntQ, dbCntD;
  logic [HOLD_W-1:0] holdCntQ, holdCntD;
  hold_phase_t       phaseQ, phaseD;
  logic              pressQ, pressD;
  logic              releaseQ, releaseD;
  logic              holdQ, holdD;

  logic              synced;
  logic              dbDone;
  logic [HOLD_W-1:0] holdLimit;

  assign synced = syncQ[1];

  // Next-state logic for debounce, strobes and hold/repeat.
  always_comb begin
    stableD   = stableQ;
    dbCntD    = '0;
    pressD    = 1'b0;
    releaseD  = 1'b0;
    holdD     = 1'b0;
    holdCntD  = holdCntQ;
    phaseD    = phaseQ;
    holdLimit = (phaseQ == HOLD_REPEAT) ? REP_LAST : HOLD_LAST;

    dbDone = (synced != stableQ) && (dbCntQ == DB_LAST);

    if (dbDone) begin
      stableD  = synced;
      pressD   = synced;
      releaseD = ~synced;
    end else if (synced != stableQ) begin
      dbCntD = dbCntQ + DB_W'(1);
    end

    // Strobes are registered in the same edge that updates the level, so the
    // hold strobe must be suppressed on the edge where the level falls.
    if (!stableQ) begin
      holdCntD = '0;
      phaseD   = HOLD_WAIT;
    end else if (holdCntQ == holdLimit) begin
      holdCntD = '0;
      phaseD   = HOLD_REPEAT;
      holdD    = ~releaseD;
    end else begin
      holdCntD = holdCntQ + HOLD_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncQ    <= '0;
      stableQ  <= 1'b0;
      dbCntQ   <= '0;
      holdCntQ <= '0;
      phaseQ   <= HOLD_WAIT;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
      holdQ    <= 1'b0;
    end else begin
      syncQ    <= {syncQ[0], btnRaw};
      stableQ  <= stableD;
      dbCntQ   <= dbCntD;
      holdCntQ <= holdCntD;
      phaseQ   <= phaseD;
      pressQ   <= pressD;
      releaseQ <= releaseD;
      holdQ    <= holdD;
    end
  end

  assign btnLevel   = stableQ;
  assign btnPress   = pressQ;
  assign btnRelease = releaseQ;
  assign btnHold    = holdQ;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: one independent conditioning channel per button pad.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_hold
);

  // One conditioning channel per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : gCh
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) uCh (
      .clk       (clk),
      .rst_n     (rst_n),
      .btnRaw    (btn_raw[i]),
      .btnLevel  (btn_level[i]),
      .btnPress  (btn_press[i]),
      .btnRelease(btn_release[i]),
      .btnHold   (btn_hold[i])
    );
  end

endmodule
